stack_xfer_sequencer: RTL and testbench

//  Registered multi-cycle sequencer for stack-based control transfers: interrupt entry, CALL, RET, RETI.

---
 rtl/cpu_ctrl_pkg.sv | 34 +++
 rtl/irq_prio_enc.sv | 29 ++
 rtl/stack_xfer_sequencer.sv | 174 +++++++++++++++++
 tb/tb_stack_xfer_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the stack-transfer sequencer: opcodes, micro-ops,
// jump selects and the sequencer state enum.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_CALL = 6'b100101;
    localparam logic [5:0] OP_RET  = 6'b100110;
    localparam logic [5:0] OP_RETI = 6'b100111;

    typedef enum logic [2:0] {
        UOP_NOP        = 3'd0,
        UOP_PUSH_FLAGS = 3'd1,
        UOP_PUSH_PC    = 3'd2,
        UOP_POP_FLAGS  = 3'd3,
        UOP_POP_PC     = 3'd4
    } uop_e;

    typedef enum logic [1:0] {
        JS_SEQ = 2'b00,
        JS_DEC = 2'b01,
        JS_IRQ = 2'b10,
        JS_POP = 2'b11
    } jsel_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IRQ_FLAGS,
        S_IRQ_PC,
        S_CALL_PC,
        S_RETI_FLAGS,
        S_RET_PC,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder, lowest index wins.
// Ports: req_i (requests), gnt_o (one-hot grant), idx_o (granted index),
//        any_o (at least one request).
module irq_prio_enc #(
    parameter int N_IRQ = 1,
    parameter int VEC_W = 2
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic [N_IRQ-1:0] gnt_o,
    output logic [VEC_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        // Scan downwards so the lowest set index is the one left standing.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = VEC_W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/stack_xfer_sequencer.sv
// Multi-cycle sequencer for interrupt entry, CALL, RET and RETI.
// Ports: clk/rst_n; opcode_i/valid_i/irq_i in; irq_ack_o, irq_vec_o, busy_o,
//        pc_save_o, fd_enable_o, pc_enable_o, jump_sel_o, uop_o, word_idx_o out.
module stack_xfer_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int N_IRQ       = 1,
    parameter int PC_WORDS    = 2,
    parameter int RET_BUBBLES = 3,
    parameter int VEC_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode_i,
    input  logic             valid_i,
    input  logic [N_IRQ-1:0] irq_i,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic [VEC_W-1:0] irq_vec_o,
    output logic             busy_o,
    output logic             pc_save_o,
    output logic             fd_enable_o,
    output logic             pc_enable_o,
    output logic [1:0]       jump_sel_o,
    output logic [2:0]       uop_o,
    output logic [1:0]       word_idx_o
);

    // Counter is 2 bits unless the drain is longer than four cycles.
    localparam int CW = (RET_BUBBLES > 4) ? $clog2(RET_BUBBLES) : 2;
    localparam logic [CW-1:0] PC_LAST = CW'(PC_WORDS - 1);
    localparam logic [CW-1:0] DR_LAST = CW'(RET_BUBBLES - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [VEC_W-1:0] vec_q, vec_d;

    logic [N_IRQ-1:0] gnt;
    logic [VEC_W-1:0] gnt_idx;
    logic             irq_any;

    logic is_call, is_ret, is_reti, is_xfer;
    logic first, pc_last, dr_last;

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .VEC_W (VEC_W)
    ) u_enc (
        .req_i (irq_i),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (irq_any)
    );

    assign is_call = valid_i && (opcode_i == OP_CALL);
    assign is_ret  = valid_i && (opcode_i == OP_RET);
    assign is_reti = valid_i && (opcode_i == OP_RETI);
    assign is_xfer = is_call || is_ret || is_reti;

    assign first   = (cnt_q == '0);
    assign pc_last = (cnt_q == PC_LAST);
    assign dr_last = (cnt_q == DR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        vec_d       = vec_q;
        irq_ack_o   = '0;
        pc_save_o   = 1'b0;
        fd_enable_o = 1'b1;
        pc_enable_o = 1'b1;
        jump_sel_o  = JS_SEQ;
        uop_o       = UOP_NOP;
        word_idx_o  = 2'd0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (irq_any) begin
                    irq_ack_o   = gnt;
                    vec_d       = gnt_idx;
                    pc_save_o   = 1'b1;
                    // Hold a pre-empted transfer so it re-decodes afterwards.
                    fd_enable_o = !is_xfer;
                    state_d     = S_IRQ_FLAGS;
                end else if (is_ret) begin
                    pc_save_o = 1'b1;
                    state_d   = S_RET_PC;
                end else if (is_reti) begin
                    pc_save_o = 1'b1;
                    state_d   = S_RETI_FLAGS;
                end else if (is_call) begin
                    pc_save_o = 1'b1;
                    state_d   = S_CALL_PC;
                end
            end
            S_IRQ_FLAGS: begin
                uop_o       = UOP_PUSH_FLAGS;
                fd_enable_o = 1'b0;
                pc_enable_o = 1'b0;
                cnt_d       = '0;
                state_d     = S_IRQ_PC;
            end
            S_IRQ_PC: begin
                uop_o       = UOP_PUSH_PC;
                word_idx_o  = cnt_q[1:0];
                fd_enable_o = pc_last;
                pc_enable_o = first;
                jump_sel_o  = first ? JS_IRQ : JS_SEQ;
                if (pc_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_CALL_PC: begin
                uop_o       = UOP_PUSH_PC;
                word_idx_o  = cnt_q[1:0];
                fd_enable_o = pc_last;
                pc_enable_o = first || pc_last;
                jump_sel_o  = first ? JS_DEC : JS_SEQ;
                if (pc_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_RETI_FLAGS: begin
                uop_o       = UOP_POP_FLAGS;
                fd_enable_o = 1'b0;
                pc_enable_o = 1'b0;
                cnt_d       = '0;
                state_d     = S_RET_PC;
            end
            S_RET_PC: begin
                // Pop in reverse push order.
                uop_o       = UOP_POP_PC;
                word_idx_o  = 2'(PC_LAST - cnt_q);
                fd_enable_o = 1'b0;
                pc_enable_o = 1'b0;
                if (pc_last) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                fd_enable_o = 1'b0;
                pc_enable_o = dr_last;
                jump_sel_o  = dr_last ? JS_POP : JS_SEQ;
                if (dr_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != S_IDLE);
    assign irq_vec_o = vec_q;

endmodule

// File: tb/tb_stack_xfer_sequencer.sv
// Self-checking bench for stack_xfer_sequencer (N_IRQ=4, PC_WORDS=2,
// RET_BUBBLES=3): directed table, corner-case sequences, random vs. model.
module tb_stack_xfer_sequencer;

    localparam int PW = 2;
    localparam int RB = 3;
    localparam logic [5:0] CALL = 6'b100101;
    localparam logic [5:0] RET  = 6'b100110;
    localparam logic [5:0] RETI = 6'b100111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode_i;
    logic       valid_i;
    logic [3:0] irq_i;
    logic [3:0] irq_ack_o;
    logic [1:0] irq_vec_o;
    logic       busy_o, pc_save_o, fd_enable_o, pc_enable_o;
    logic [1:0] jump_sel_o;
    logic [2:0] uop_o;
    logic [1:0] word_idx_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stack_xfer_sequencer #(
        .N_IRQ       (4),
        .PC_WORDS    (PW),
        .RET_BUBBLES (RB),
        .VEC_W       (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode_i    (opcode_i),
        .valid_i     (valid_i),
        .irq_i       (irq_i),
        .irq_ack_o   (irq_ack_o),
        .irq_vec_o   (irq_vec_o),
        .busy_o      (busy_o),
        .pc_save_o   (pc_save_o),
        .fd_enable_o (fd_enable_o),
        .pc_enable_o (pc_enable_o),
        .jump_sel_o  (jump_sel_o),
        .uop_o       (uop_o),
        .word_idx_o  (word_idx_o)
    );

    // Packed view: busy,save,fd,pc,js[2],uop[3],widx[2],ack[4],vec[2]
    logic [16:0] act;
    assign act = {busy_o, pc_save_o, fd_enable_o, pc_enable_o, jump_sel_o,
                  uop_o, word_idx_o, irq_ack_o, irq_vec_o};
    logic [16:0] last_act;

    function automatic logic [16:0] mk(input logic b, input logic s,
                                       input logic f, input logic p,
                                       input logic [1:0] j,
                                       input logic [2:0] u,
                                       input logic [1:0] w,
                                       input logic [3:0] a,
                                       input logic [1:0] v);
        return {b, s, f, p, j, u, w, a, v};
    endfunction

    localparam logic [16:0] RST_VEC = 17'b0_0_1_1_00_000_00_0000_00;

    task automatic chk(input string name, input logic [16:0] got,
                       input logic [16:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (busy,save,fd,pc,js,uop,w,ack,vec)",
                     name, got, exp);
        end
    endtask

    // Reference model: a script of expected per-cycle outputs, built at
    // the start of each sequence from the sequence rules.
    logic [16:0] scr[$];
    logic [1:0]  mvec = 2'd0;

    function automatic int low(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        return 0;
    endfunction

    function automatic logic [16:0] model_exp(input logic [5:0] op,
                                              input logic v,
                                              input logic [3:0] irq);
        logic xfer;
        logic start;
        logic [3:0] ack;
        if (scr.size() != 0) return scr[0];
        xfer  = v && (op == CALL || op == RET || op == RETI);
        start = (irq != 0) || xfer;
        ack   = (irq != 0) ? 4'(1 << low(irq)) : 4'd0;
        return mk(0, start, !((irq != 0) && xfer), 1, 2'd0, 3'd0, 2'd0,
                  ack, mvec);
    endfunction

    task automatic push_ret(input logic reti);
        if (reti) scr.push_back(mk(1, 0, 0, 0, 2'd0, 3'd3, 2'd0, 4'd0, mvec));
        for (int i = 0; i < PW; i++)
            scr.push_back(mk(1, 0, 0, 0, 2'd0, 3'd4, 2'(PW - 1 - i), 4'd0, mvec));
        for (int b = 0; b < RB; b++) begin
            logic l;
            l = (b == RB - 1);
            scr.push_back(mk(1, 0, 0, l, l ? 2'd3 : 2'd0, 3'd0, 2'd0, 4'd0, mvec));
        end
    endtask

    task automatic model_adv(input logic [5:0] op, input logic v,
                             input logic [3:0] irq);
        if (scr.size() != 0) begin
            void'(scr.pop_front());
        end else if (irq != 0) begin
            mvec = 2'(low(irq));
            scr.push_back(mk(1, 0, 0, 0, 2'd0, 3'd1, 2'd0, 4'd0, mvec));
            for (int w = 0; w < PW; w++)
                scr.push_back(mk(1, 0, w == PW - 1, w == 0,
                                 (w == 0) ? 2'd2 : 2'd0, 3'd2, 2'(w),
                                 4'd0, mvec));
        end else if (v && op == RET) begin
            push_ret(1'b0);
        end else if (v && op == RETI) begin
            push_ret(1'b1);
        end else if (v && op == CALL) begin
            for (int w = 0; w < PW; w++)
                scr.push_back(mk(1, 0, w == PW - 1, (w == 0) || (w == PW - 1),
                                 (w == 0) ? 2'd1 : 2'd0, 3'd2, 2'(w),
                                 4'd0, mvec));
        end
    endtask

    // Entered at posedge+1; checks at negedge; returns at next posedge+1.
    task automatic drive_check(input logic [5:0] op, input logic v,
                               input logic [3:0] irq, input logic use_exp,
                               input logic [16:0] exp, input string name);
        opcode_i = op;
        valid_i  = v;
        irq_i    = irq;
        @(negedge clk);
        last_act = act;
        chk(name, act, use_exp ? exp : model_exp(op, v, irq));
        model_adv(op, v, irq);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [5:0] op, input logic v,
                        input logic [3:0] irq, input string name);
        drive_check(op, v, irq, 1'b0, 17'd0, name);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        v;
        logic [3:0]  irq;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // CALL: PUSH_PC w0 (jump 01), PUSH_PC w1 (fd 1), IDLE.
        tbl[0]  = '{CALL, 1'b1, 4'd0, mk(0, 1, 1, 1, 2'd0, 3'd0, 2'd0, 4'd0, 2'd0)};
        tbl[1]  = '{RET,  1'b1, 4'd0, mk(1, 0, 0, 1, 2'd1, 3'd2, 2'd0, 4'd0, 2'd0)};
        tbl[2]  = '{6'd0, 1'b0, 4'd0, mk(1, 0, 1, 1, 2'd0, 3'd2, 2'd1, 4'd0, 2'd0)};
        tbl[3]  = '{6'd0, 1'b0, 4'd0, RST_VEC};
        // RETI: POP_FLAGS, POP_PC w1, w0, three drain cycles.
        tbl[4]  = '{RETI, 1'b1, 4'd0, mk(0, 1, 1, 1, 2'd0, 3'd0, 2'd0, 4'd0, 2'd0)};
        tbl[5]  = '{6'd0, 1'b0, 4'd0, mk(1, 0, 0, 0, 2'd0, 3'd3, 2'd0, 4'd0, 2'd0)};
        tbl[6]  = '{CALL, 1'b1, 4'd0, mk(1, 0, 0, 0, 2'd0, 3'd4, 2'd1, 4'd0, 2'd0)};
        tbl[7]  = '{6'd0, 1'b0, 4'd0, mk(1, 0, 0, 0, 2'd0, 3'd4, 2'd0, 4'd0, 2'd0)};
        tbl[8]  = '{6'd0, 1'b0, 4'd0, mk(1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 4'd0, 2'd0)};
        tbl[9]  = '{6'd0, 1'b0, 4'd0, mk(1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 4'd0, 2'd0)};
        tbl[10] = '{6'd0, 1'b0, 4'd0, mk(1, 0, 0, 1, 2'd3, 3'd0, 2'd0, 4'd0, 2'd0)};
        tbl[11] = '{6'd0, 1'b0, 4'd0, RST_VEC};
        // RET without valid_i: no start, no pc_save_o.
        tbl[12] = '{RET,  1'b0, 4'd0, RST_VEC};
        tbl[13] = '{6'd0, 1'b0, 4'd0, RST_VEC};

        rst_n    = 1'b0;
        opcode_i = '0;
        valid_i  = 1'b0;
        irq_i    = '0;
        #12;
        chk("reset_state", act, RST_VEC);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++)
            drive_check(tbl[i].op, tbl[i].v, tbl[i].irq, 1'b1, tbl[i].exp,
                        $sformatf("tbl[%0d]", i));

        // IRQ 1010 pre-empts a same-cycle RET, which runs afterwards.
        step(RET, 1'b1, 4'b1010, "irq_vs_ret");
        chk("irq_ack", 17'(last_act[5:2]), 17'(4'b0010));
        chk("irq_fd_hold", 17'(last_act[14]), 17'd0);
        step(RET, 1'b1, 4'b0000, "irq_flags");
        chk("irq_vec", 17'(last_act[1:0]), 17'd1);
        step(RET, 1'b1, 4'b0000, "irq_pc0");
        step(RET, 1'b1, 4'b0000, "irq_pc1");
        step(RET, 1'b1, 4'b0000, "ret_after_irq");
        chk("ret_after_irq_save", 17'(last_act[15]), 17'd1);
        for (int i = 0; i < PW + RB; i++) step(6'd0, 1'b0, 4'd0, "ret_seq");
        step(6'd0, 1'b0, 4'd0, "idle_after_ret");

        // IRQ rising during DRAIN waits for IDLE.
        step(RET, 1'b1, 4'd0, "ret2_start");
        for (int i = 0; i < PW; i++) step(6'd0, 1'b0, 4'd0, "ret2_pop");
        for (int i = 0; i < RB; i++) begin
            step(6'd0, 1'b0, 4'b0001, "drain_irq");
            chk("drain_no_ack", 17'(last_act[5:2]), 17'd0);
        end
        step(6'd0, 1'b0, 4'b0001, "irq_first_idle");
        chk("irq_first_idle_ack", 17'(last_act[5:2]), 17'(4'b0001));
        for (int i = 0; i < 1 + PW; i++) step(6'd0, 1'b0, 4'd0, "irq2_seq");

        // Reset in the middle of RET_PC.
        step(RET, 1'b1, 4'd0, "ret3_start");
        step(6'd0, 1'b0, 4'd0, "ret3_pop_w1");
        rst_n   = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("reset_mid_ret", act, RST_VEC);
        scr.delete();
        mvec = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(6'd0, 1'b0, 4'd0, "idle_after_reset");
        step(RET, 1'b1, 4'd0, "ret_after_reset");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [5:0] op;
            logic [3:0] irq;
            logic       v;
            case ($urandom_range(0, 3))
                0: op = CALL;
                1: op = RET;
                2: op = RETI;
                default: op = 6'($urandom);
            endcase
            v   = ($urandom_range(0, 3) != 0);
            irq = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step(op, v, irq, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
